// File: rtl/mem_access_unit.sv
// Load/store bridge from the multicycle datapath to a valid/ready word-addressed memory bus.
// Optional REQ-state timeout abort is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic                  mem_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state, next_state;
    logic        req_any;
    logic        legal;
    logic        timeout_hit;
    logic        err_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    assign req_any = req_read | req_write;

    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~addr[0];
            3'b010:         legal = (addr[1:0] == 2'b00);
            default:        legal = 1'b0;
        endcase
    end

    // Store data is replicated across lanes so the strobes alone select the target bytes.
    always_comb begin
        st_strb  = 4'b1111;
        st_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << addr[1:0];
                st_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_strb  = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte  = mem_rdata[{off_q, 3'b000} +: 8];
        ld_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_value = mem_rdata;
        case (f3_q)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_value = {24'h0, ld_byte};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_value = {16'h0, ld_half};
            default: ld_value = mem_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    assign timeout_hit = (state == REQ) && !mem_ready && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state != REQ) begin
            tmo_cnt <= '0;
        end else if (!mem_ready) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_param;
    assign unused_timeout_param = ^TIMEOUT_CYCLES;
    assign timeout_hit          = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req_any) next_state = legal ? REQ : RESP;
            REQ:  if (mem_ready || timeout_hit) next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == RESP);
    assign err  = done & err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            err_q     <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
        end else begin
            mem_valid <= (next_state == REQ);
            case (state)
                IDLE: begin
                    if (req_any) begin
                        err_q <= ~legal;
                        f3_q  <= funct3;
                        off_q <= addr[1:0];
                        if (legal) begin
                            mem_we    <= req_write;
                            mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_wstrb <= req_write ? st_strb : 4'b0000;
                            mem_wdata <= st_wdata;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (!mem_we) rdata <= ld_value;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected bus requests and
// completions into queues, a negedge monitor pops and compares them.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_read = 1'b0, req_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        done, err, busy;
    logic        mem_valid, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req_read(req_read), .req_write(req_write), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata),
        .done(done), .err(err), .busy(busy),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wd;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
    } done_t;

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, mrd;
        int unsigned lat;
        logic        hold;
        logic [3:0]  strb;
        logic [31:0] bwd, exp_rd;
        logic        exp_err;
    } vec_t;

    bus_t        bus_q[$];
    done_t       done_q[$];
    vec_t        vq[$];
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void add(logic rd, logic wr, logic [2:0] f3, logic [31:0] a,
                                logic [31:0] wd, int unsigned lat, logic [31:0] mrd,
                                logic hold, logic [3:0] strb, logic [31:0] bwd,
                                logic [31:0] exp_rd, logic exp_err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.lat = lat;
        v.mrd = mrd; v.hold = hold; v.strb = strb; v.bwd = bwd;
        v.exp_rd = exp_rd; v.exp_err = exp_err;
        vq.push_back(v);
    endfunction

    // Monitor: every bus handshake and every done pulse must match a queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (mem_valid && bus_q.size() == 0) begin
                chk("unexpected_valid", {31'b0, mem_valid}, 32'd0);
            end else if (mem_valid && mem_ready) begin
                bus_t b;
                b = bus_q.pop_front();
                chk("mem_we", {31'b0, mem_we}, {31'b0, b.we});
                chk("mem_addr", mem_addr, b.addr);
                chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, b.strb});
                if (b.we) chk("mem_wdata", mem_wdata, b.wd);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("extra_done", {31'b0, done}, 32'd0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("rdata", rdata, d.rdata);
                    chk("err", {31'b0, err}, {31'b0, d.err});
                    chk("done_cycle", cyc, d.cyc);
                end
            end else if (err) begin
                chk("err_without_done", {31'b0, err}, 32'd0);
            end
        end
    end

    task automatic wait_idle(int unsigned bound);
        for (int k = 0; k < int'(bound); k++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        if (busy) chk("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic run(vec_t v);
        int unsigned c0;
        c0 = cyc;
        if (!v.exp_err) bus_q.push_back('{we: v.wr, addr: {v.addr[31:2], 2'b00}, strb: v.strb, wd: v.bwd});
        done_q.push_back('{rdata: v.exp_rd, err: v.exp_err,
                           cyc: c0 + (v.exp_err ? 32'd1 : 32'd2 + v.lat)});
        req_read = v.rd; req_write = v.wr; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        @(posedge clk); #1;
        if (!v.hold) begin req_read = 1'b0; req_write = 1'b0; end
        if (!v.exp_err) begin
            repeat (v.lat) begin @(posedge clk); #1; end
            mem_ready = 1'b1; mem_rdata = v.mrd;
            @(posedge clk); #1;
            mem_ready = 1'b0;
        end
        wait_idle(20);
        req_read = 1'b0; req_write = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //   rd wr  f3      addr          wdata        lat mrd           hold strb     bwd           exp_rd        err
        add(1, 0, 3'b010, 32'h0000_0100, 32'h0,          3, 32'hDEADBEEF, 0, 4'b0000, 32'h0,        32'hDEADBEEF, 0);
        add(1, 0, 3'b000, 32'h0000_0103, 32'h0,          0, 32'h80123456, 0, 4'b0000, 32'h0,        32'hFFFFFF80, 0);
        add(1, 0, 3'b100, 32'h0000_0103, 32'h0,          0, 32'h80123456, 0, 4'b0000, 32'h0,        32'h00000080, 0);
        add(0, 1, 3'b001, 32'h0000_0202, 32'h0000ABCD,   0, 32'h0,        0, 4'b1100, 32'hABCDABCD, 32'h00000080, 0);
        add(1, 0, 3'b010, 32'h0000_0101, 32'h0,          0, 32'h0,        0, 4'b0000, 32'h0,        32'h00000080, 1);
        add(1, 0, 3'b011, 32'h0000_0100, 32'h0,          0, 32'h0,        0, 4'b0000, 32'h0,        32'h00000080, 1);
        add(1, 1, 3'b010, 32'h0000_0300, 32'h12345678,   1, 32'h0,        0, 4'b1111, 32'h12345678, 32'h00000080, 0);
        add(1, 0, 3'b001, 32'h0000_0102, 32'h0,          2, 32'h80017FFF, 0, 4'b0000, 32'h0,        32'hFFFF8001, 0);
        add(1, 0, 3'b101, 32'h0000_0100, 32'h0,          0, 32'h8001F00D, 0, 4'b0000, 32'h0,        32'h0000F00D, 0);
        add(0, 1, 3'b000, 32'h0000_0401, 32'h000000A5,   0, 32'h0,        0, 4'b0010, 32'hA5A5A5A5, 32'h0000F00D, 0);
        add(0, 1, 3'b001, 32'h0000_0203, 32'h00001234,   0, 32'h0,        0, 4'b0000, 32'h0,        32'h0000F00D, 1);
        add(1, 0, 3'b000, 32'h0000_0102, 32'h0,          1, 32'h117F2233, 1, 4'b0000, 32'h0,        32'h0000007F, 0);
        add(1, 0, 3'b110, 32'h0000_0104, 32'h0,          0, 32'h0,        0, 4'b0000, 32'h0,        32'h0000007F, 1);

        #2;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_flags", {27'b0, done, err, busy, mem_valid, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (vq[i]) run(vq[i]);

        // Reset in the middle of a bus request abandons it immediately.
        bus_q.push_back('{we: 1'b0, addr: 32'h600, strb: 4'b0000, wd: 32'h0});
        req_read = 1'b1; funct3 = 3'b010; addr = 32'h600;
        @(posedge clk); #1;
        req_read = 1'b0;
        chk("pre_reset_valid", {31'b0, mem_valid}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_reset_valid", {31'b0, mem_valid}, 32'd0);
        chk("mid_reset_busy", {31'b0, busy}, 32'd0);
        chk("mid_reset_rdata", rdata, 32'h0);
        bus_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        begin
            vec_t v;
            v.rd = 1; v.wr = 0; v.f3 = 3'b010; v.addr = 32'h101; v.wdata = 0; v.lat = 0;
            v.mrd = 0; v.hold = 0; v.strb = 0; v.bwd = 0; v.exp_rd = 32'h0; v.exp_err = 1;
            run(v);
        end

`ifdef MEM_TIMEOUT_EN
        begin
            int unsigned c0;
            c0 = cyc;
            bus_q.push_back('{we: 1'b0, addr: 32'h500, strb: 4'b0000, wd: 32'h0});
            done_q.push_back('{rdata: 32'h0, err: 1'b1, cyc: c0 + 5});
            req_read = 1'b1; funct3 = 3'b010; addr = 32'h500;
            @(posedge clk); #1;
            req_read = 1'b0;
            wait_idle(30);
            bus_q.delete();
            @(posedge clk); #1;
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("missing_done", done_q.size(), 32'd0);
        chk("missing_bus", bus_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
